// File: rtl/encode_unit_pkg.sv
// encode_unit_pkg: shared format codes, RV32 opcodes and the pure instruction encoder.
package encode_unit_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } enc_req_t;

    // B and J offsets are halfword-granular, so an odd byte offset cannot be encoded
    function automatic logic fmt_legal(input enc_req_t r);
        return (r.fmt <= FMT_J) && !((r.fmt == FMT_B || r.fmt == FMT_J) && r.imm[0]);
    endfunction

    function automatic logic [31:0] encode(input enc_req_t r);
        logic [31:0] i;
        i = r.imm;
        case (r.fmt)
            FMT_R:   return {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
            FMT_I:   return {i[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S:   return {i[11:5], r.rs2, r.rs1, r.funct3, i[4:0], r.opcode};
            FMT_B:   return {i[12], i[10:5], r.rs2, r.rs1, r.funct3, i[4:1], i[11], r.opcode};
            FMT_U:   return {i[31:12], r.rd, r.opcode};
            FMT_J:   return {i[20], i[10:1], i[11], i[19:12], r.rd, r.opcode};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/encode_fifo.sv
// encode_fifo: two-entry FIFO with flush; head always sits in slot 0.
module encode_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [2];
    logic [1:0]       count;
    logic             wr_sel;

    // a pop shifts slot 1 down, so the write slot moves down with it
    assign wr_sel = count[0] ^ pop;
    assign head   = mem[0];
    assign empty  = count == 2'd0;
    assign full   = count[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            count  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop) mem[0] <= mem[1];
            if (push) mem[wr_sel] <= din;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/encode_unit.sv
// encode_unit: encodes RV32 instruction fields and streams the words into instruction memory.
module encode_unit
    import encode_unit_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_base,
    input  logic [ADDRESS_BITS-1:0] base_addr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              fmt,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [4:0]              rd,
    input  logic [31:0]             imm,
    output logic                    mem_wEn,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [31:0]             mem_data,
    input  logic                    mem_ready,
    output logic [15:0]             inst_count,
    output logic                    err
);
    if (CORE < 0 || ADDRESS_BITS < 3) begin : g_bad_param
        $error("encode_unit: CORE must be >= 0 and ADDRESS_BITS >= 3");
    end

    enc_req_t req;
    logic     accept;
    logic     legal;
    logic     push;
    logic     pop;
    logic     empty;
    logic     full;

    assign req      = {fmt, opcode, funct3, funct7, rs1, rs2, rd, imm};
    assign legal    = fmt_legal(req);
    assign in_ready = reset && !load_base && !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign mem_wEn  = !empty;
    // load_base discards the pending write even if memory is ready
    assign pop      = mem_wEn && mem_ready && !load_base;

    encode_fifo #(.WIDTH(32)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (load_base),
        .push  (push),
        .pop   (pop),
        .din   (encode(req)),
        .head  (mem_data),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr   <= '0;
            inst_count <= '0;
            err        <= 1'b0;
        end else if (load_base) begin
            mem_addr   <= base_addr;
            inst_count <= '0;
            err        <= 1'b0;
        end else begin
            if (pop) begin
                mem_addr   <= mem_addr + ADDRESS_BITS'(4);
                inst_count <= inst_count + 16'd1;
            end
            if (accept && !legal) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_encode_unit.sv
// tb_encode_unit: scoreboard bench; a field-arithmetic reference model predicts every memory write.
module tb_encode_unit;
    import encode_unit_pkg::*;

    logic        clock = 0, reset = 0, load_base = 0, in_valid = 0, mem_ready = 0;
    logic [19:0] base_addr = 0;
    logic [2:0]  fmt = 0, funct3 = 0;
    logic [6:0]  opcode = 0, funct7 = 0;
    logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
    logic [31:0] imm = 0, want = 0;
    logic        in_ready, mem_wEn, err;
    logic [19:0] mem_addr;
    logic [31:0] mem_data;
    logic [15:0] inst_count;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ent_t;

    ent_t        sb[$];
    logic [19:0] exp_addr = 0;
    logic [15:0] exp_cnt = 0;
    logic        exp_err = 0, acc_ok = 0;
    int          checks = 0, failures = 0;

    encode_unit #(.CORE(0), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset), .load_base(load_base), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .inst_count(inst_count), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // reference: place each field at its bit position with shifts and masks
    function automatic logic [31:0] model_word(input logic [2:0] f, input logic [6:0] op,
        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b,
        input logic [4:0] d, input logic [31:0] im);
        logic [31:0] o, r1, r2, dd, t3;
        o  = {25'd0, op};
        r1 = {27'd0, a} << 15;
        r2 = {27'd0, b} << 20;
        dd = {27'd0, d} << 7;
        t3 = {29'd0, f3} << 12;
        case (f)
            3'd0: return ({25'd0, f7} << 25) | r2 | r1 | t3 | dd | o;
            3'd1: return ((im & 32'hFFF) << 20) | r1 | t3 | dd | o;
            3'd2: return (((im >> 5) & 32'h7F) << 25) | r2 | r1 | t3 | ((im & 32'h1F) << 7) | o;
            3'd3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | t3
                         | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | o;
            3'd4: return (im & 32'hFFFFF000) | dd | o;
            3'd5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | dd | o;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        return v[bits-1] ? (v | (32'hFFFFFFFF << bits)) : (v & ~(32'hFFFFFFFF << bits));
    endfunction

    // decoder round trip on the written word
    task automatic dec_check(input ent_t e, input logic [31:0] w);
        logic [31:0] d, x;
        chk("dec_opcode", 32'(w[6:0]), 32'(e.op));
        if (e.fmt != 3'd2 && e.fmt != 3'd3) chk("dec_rd", 32'(w[11:7]), 32'(e.rd));
        if (e.fmt <= 3'd3) chk("dec_funct3", 32'(w[14:12]), 32'(e.f3));
        if (e.fmt == 3'd0) chk("dec_funct7", 32'(w[31:25]), 32'(e.f7));
        else begin
            case (e.fmt)
                3'd1:    begin d = sext({20'd0, w[31:20]}, 12); x = sext(e.imm, 12); end
                3'd2:    begin d = sext({20'd0, w[31:25], w[11:7]}, 12); x = sext(e.imm, 12); end
                3'd3:    begin d = sext({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13); x = sext(e.imm, 13); end
                3'd4:    begin d = {w[31:12], 12'd0}; x = e.imm & 32'hFFFFF000; end
                default: begin d = sext({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); x = sext(e.imm, 21); end
            endcase
            chk("dec_imm", d, x);
        end
    endtask

    always @(negedge reset) begin
        sb.delete();
        exp_addr = 0;
        exp_cnt  = 0;
        exp_err  = 0;
    end

    // monitor: compare state every cycle, pop the scoreboard on each completed write
    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_mem_wEn", 32'(mem_wEn), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_data", mem_data, 0);
            chk("rst_inst_count", 32'(inst_count), 0);
            chk("rst_err", 32'(err), 0);
            acc_ok = 0;
        end else begin
            logic rdy;
            rdy = sb.size() < 2 && !load_base;
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("mem_wEn", 32'(mem_wEn), 32'(sb.size() != 0));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("inst_count", 32'(inst_count), 32'(exp_cnt));
            chk("err", 32'(err), 32'(exp_err));
            if (sb.size() != 0) chk("mem_data", mem_data, sb[0].word);
            acc_ok = in_valid && rdy;
            if (sb.size() != 0 && mem_ready && !load_base) begin
                dec_check(sb[0], mem_data);
                void'(sb.pop_front());
                exp_addr = exp_addr + 20'd4;
                exp_cnt  = exp_cnt + 16'd1;
            end
        end
    end

    // model: apply load_base and accepted requests at the clock edge
    always @(posedge clock) begin
        if (reset) begin
            if (load_base) begin
                sb.delete();
                exp_addr = base_addr;
                exp_cnt  = 0;
                exp_err  = 0;
            end else if (acc_ok) begin
                if (fmt > 3'd5 || ((fmt == 3'd3 || fmt == 3'd5) && imm[0])) exp_err = 1;
                else sb.push_back('{want, fmt, opcode, funct3, funct7, rd, imm});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic load(input logic [19:0] a);
        load_base = 1;
        base_addr = a;
        idle(1);
        load_base = 0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
        input logic [31:0] im, input logic [31:0] w);
        logic ok;
        fmt = f; opcode = op; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; rd = d; imm = im;
        want = w;
        in_valid = 1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept t=%0t", $time);
        end
        in_valid = 0;
    endtask

    initial begin
        idle(3);
        reset = 1;
        idle(1);
        mem_ready = 1;
        load(20'h100);
        send(FMT_I, OP_IMM, 0, 0, 0, 0, 1, 5, 32'h00500093);
        idle(2);
        load(20'h100);
        send(FMT_R, OP_REG, 0, 0, 1, 2, 3, 0, 32'h002081B3);
        send(FMT_S, OP_STORE, 3'd2, 0, 1, 2, 0, 8, 32'h0020A423);
        send(FMT_B, OP_BRANCH, 0, 0, 1, 2, 0, 8, 32'h00208463);
        idle(3);
        chk("count_after_three", 32'(inst_count), 3);
        load(20'h200);
        mem_ready = 0;
        send(FMT_J, OP_JAL, 0, 0, 0, 0, 1, 16, 32'h010000EF);
        send(FMT_U, OP_LUI, 0, 0, 0, 0, 5, 32'h12345000, 32'h123452B7);
        in_valid = 1;
        idle(4);
        in_valid = 0;
        mem_ready = 1;
        idle(3);
        send(FMT_B, OP_BRANCH, 0, 0, 1, 2, 0, 7, 0);
        send(3'd7, OP_REG, 0, 0, 1, 2, 3, 0, 0);
        idle(2);
        load(20'h0);
        load(20'hFFFFC);
        send(FMT_I, OP_IMM, 0, 0, 2, 0, 4, 32'hFFFFFFF0, model_word(1, OP_IMM, 0, 0, 2, 0, 4, 32'hFFFFFFF0));
        send(FMT_I, OP_LOAD, 3'd2, 0, 3, 0, 6, 12, model_word(1, OP_LOAD, 2, 0, 3, 0, 6, 12));
        idle(3);
        load(20'h102);
        send(FMT_U, OP_AUIPC, 0, 0, 0, 0, 7, 32'hABCDE000, model_word(4, OP_AUIPC, 0, 0, 0, 0, 7, 32'hABCDE000));
        idle(2);
        // reset with a full FIFO must clear outputs without waiting for a clock edge
        mem_ready = 0;
        load(20'h40);
        send(FMT_R, OP_REG, 0, 7'h20, 4, 5, 6, 0, model_word(0, OP_REG, 0, 7'h20, 4, 5, 6, 0));
        send(FMT_I, OP_JALR, 0, 0, 1, 0, 0, 0, model_word(1, OP_JALR, 0, 0, 1, 0, 0, 0));
        #3 reset = 0;
        #1;
        chk("async_in_ready", 32'(in_ready), 0);
        chk("async_mem_wEn", 32'(mem_wEn), 0);
        chk("async_mem_addr", 32'(mem_addr), 0);
        chk("async_mem_data", mem_data, 0);
        chk("async_inst_count", 32'(inst_count), 0);
        chk("async_err", 32'(err), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        mem_ready = 1;
        send(FMT_S, OP_STORE, 0, 0, 9, 10, 0, 32'hFFFFF801, model_word(2, OP_STORE, 0, 0, 9, 10, 0, 32'hFFFFF801));
        idle(3);
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            in_valid = $urandom_range(0, 3) != 0;
            fmt = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            imm = $urandom;
            if (fmt == 3'd3 || fmt == 3'd5) imm[0] = ($urandom_range(0, 7) == 0);
            want = model_word(fmt, opcode, funct3, funct7, rs1, rs2, rd, imm);
            mem_ready = $urandom_range(0, 3) != 0;
            load_base = $urandom_range(0, 39) == 0;
            base_addr = 20'($urandom);
        end
        idle(1);
        in_valid = 0;
        load_base = 0;
        mem_ready = 1;
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encode_unit.md
ENCODE_UNIT -- requirements
Module: encode_unit

Interface
REQ-001 Parameter CORE, default 0, core index; no functional effect.
REQ-002 Parameter ADDRESS_BITS, default 20, instruction-memory address width.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_base  input  1  one-cycle pulse: restart the write sequence at base_addr.
REQ-006 base_addr  input  ADDRESS_BITS  start address captured on load_base.
REQ-007 in_valid  input  1  instruction fields valid.
REQ-008 in_ready  output  1  encoder can accept fields this cycle.
REQ-009 fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 illegal.
REQ-010 opcode  input  7; funct3  input  3; funct7  input  7; rs1, rs2, rd  input  5 each; imm  input  32 (byte-offset immediate, unshifted).
REQ-011 mem_wEn  output  1  instruction-memory write request.
REQ-012 mem_addr  output  ADDRESS_BITS  write address.
REQ-013 mem_data  output  32  encoded instruction.
REQ-014 mem_ready  input  1  memory accepts the write this cycle.
REQ-015 inst_count  output  16  number of instructions written since the last load_base or reset.
REQ-016 err  output  1  sticky flag: an illegal request was dropped.

Function
REQ-017 An accept SHALL occur when in_valid and in_ready are both high on a rising edge.
REQ-018 R: {funct7, rs2, rs1, funct3, rd, opcode}; I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-019 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-020 U: {imm[31:12], rd, opcode}; J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-021 Feeding any encoded word back through the team's decoder SHALL reproduce opcode, funct3, funct7, rd, the sign-extended immediate, and the branch/JAL offsets.
REQ-022 An accepted request with fmt 6/7, or fmt B/J with imm[0]=1, SHALL be dropped (not queued) and SHALL set err.
REQ-023 Legal encoded words SHALL be pushed into a 2-entry FIFO.
REQ-024 mem_wEn SHALL equal "FIFO not empty", and mem_data SHALL equal the FIFO head; the first write is visible the cycle after the accept (latency 1).
REQ-025 A write completes when mem_wEn and mem_ready are both high. On completion: pop the head, mem_addr += 4 modulo 2^ADDRESS_BITS, inst_count += 1 (wrapping at 2^16).
REQ-026 mem_addr, mem_data and mem_wEn SHALL hold stable while mem_wEn=1 and mem_ready=0.
REQ-027 in_ready SHALL be high when FIFO occupancy < 2 and load_base=0; a simultaneous push and pop at full is not allowed (in_ready=0 at full).
REQ-028 A simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with order preserved.
REQ-029 load_base SHALL flush the FIFO, set mem_addr=base_addr, clear inst_count and err, and ignore in_valid in that cycle; a pending write in that cycle is discarded even if mem_ready=1.
REQ-030 A base_addr[1:0] value other than 0 SHALL be loaded unchanged; the encoder does not enforce alignment.

Reset
REQ-031 On reset low (asynchronous): FIFO empty, mem_wEn=0, mem_addr=0, mem_data=0, inst_count=0, err=0. in_ready SHALL be 0 while reset is asserted.
REQ-032 Reset deasserted mid-write SHALL lose the in-flight entry; the first accept is allowed on the first edge after release.

Structure
REQ-033 The format codes (FMT_R..FMT_J) and the RV32 opcode constants SHALL live in the shared core package, so that the decoder and the benches use the same values.
REQ-034 The encoding SHALL be a pure combinational function in the package. The 2-entry FIFO SHALL be one sub-module, encode_fifo (parameterised width, depth 2).

Verification
REQ-035 load_base with base_addr=0x100, then I-type op=0x13, rd=1, rs1=0, f3=0, imm=5 -> the next cycle mem_wEn=1, mem_addr=0x100, mem_data=0x00500093.
REQ-036 Back-to-back R (add x3,x1,x2), S (sw x2,8(x1)), B (beq x1,x2,8) with mem_ready=1 -> the words 0x002081B3, 0x0020A423, 0x00208463 are written at 0x100, 0x104, 0x108, and inst_count=3.
REQ-037 J (jal x1,16) and U (lui x5,0x12345) with mem_ready held at 0 for 4 cycles -> in_ready=0 after 2 accepts, outputs stable; after release the words 0x010000EF then 0x123452B7 are written.
REQ-038 fmt=3 with imm=7, then fmt=7 -> no write occurs, err=1, inst_count unchanged; a subsequent load_base clears err.
REQ-039 base_addr=2^20-4 with two writes -> the second write is at address 0 (wrap-around).
REQ-040 Reset asserted while the FIFO holds 2 entries -> all outputs go to their reset values immediately, with no clock edge required; no write occurs after release.
